// File: rtl/alu_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// alu_sequencer_pkg
// Shared definitions for the ALU front-end sequencer:
//   op_e    - request opcodes as seen on the opcode / au_sel buses
//   state_e - sequencer FSM states
//   FLAG_*  - bit positions inside the 4-bit flags response field
//   uses_unit() - true when an op is handed to the divider or multiplier
// -----------------------------------------------------------------------------
package alu_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_DIV = 2'b10,
    OP_MUL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  // flags = {timeout, div_by_zero, overflow, carry_borrow}
  localparam int FLAG_W       = 4;
  localparam int FLAG_CARRY   = 0;
  localparam int FLAG_OVR     = 1;
  localparam int FLAG_DBZ     = 2;
  localparam int FLAG_TIMEOUT = 3;

  // A divide by zero is answered locally, so only a non-zero divisor or a
  // multiply needs the start/done handshake.
  function automatic logic uses_unit(input op_e op, input logic b_is_zero);
    return (op == OP_MUL) || ((op == OP_DIV) && !b_is_zero);
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// -----------------------------------------------------------------------------
// seq_watchdog
// Cycle counter guarding the wait for a divider/multiplier done.
//   clk, rst  - clock, asynchronous active-low reset
//   clear     - restart the count at zero (wins over enable)
//   enable    - advance the count by one
//   expired   - the current cycle is the TIMEOUT-th enabled cycle since clear
// TW must be wide enough that 2**TW > TIMEOUT.
// -----------------------------------------------------------------------------
module seq_watchdog #(
  parameter int TIMEOUT = 64,
  parameter int TW      = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TW-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + TW'(1);
    end
  end

  // The count holds the number of wait cycles already spent, so the cycle
  // that sees TIMEOUT-1 is the last one allowed.
  assign expired = (count == TW'(TIMEOUT - 1));

endmodule

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
// Front-end controller for the 8-bit arithmetic datapath. Accepts one request
// at a time, drives registered operands/op select to the datapath, sequences
// the divider and multiplier with a start pulse / done handshake under a
// watchdog, and holds the response until it is consumed.
//
// Ports
//   clk, rst                      clock, asynchronous active-low reset
//   in_valid/in_ready             request handshake (opcode, op_a, op_b)
//   out_valid/out_ready           response handshake (result, result_hi, flags)
//   au_a, au_b, au_sel            registered operands and op select to datapath
//   au_res, au_cout, au_ovr       combinational ADD/SUB result from datapath
//   div_start/div_done/div_quot/div_rem   divider handshake and outputs
//   mul_start/mul_done/mul_prod           multiplier handshake and product
// -----------------------------------------------------------------------------
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64,
  parameter int TW      = 7
) (
  input  logic               clk,
  input  logic               rst,
  // request channel
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         opcode,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  // response channel
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic [WIDTH-1:0]   result_hi,
  output logic [FLAG_W-1:0]  flags,
  // datapath interface
  output logic [WIDTH-1:0]   au_a,
  output logic [WIDTH-1:0]   au_b,
  output logic [1:0]         au_sel,
  input  logic [WIDTH-1:0]   au_res,
  input  logic               au_cout,
  input  logic               au_ovr,
  output logic               div_start,
  input  logic               div_done,
  input  logic [WIDTH-1:0]   div_quot,
  input  logic [WIDTH-1:0]   div_rem,
  output logic               mul_start,
  input  logic               mul_done,
  input  logic [2*WIDTH-1:0] mul_prod
);

  state_e state;
  op_e    au_op;
  logic   unit_done;
  logic   wd_clear;
  logic   wd_enable;
  logic   wd_expired;

  assign au_sel = au_op;

  // Only the unit that was started may end the wait.
  assign unit_done = (au_op == OP_DIV) ? div_done : mul_done;

  assign wd_clear  = (state == S_ISSUE);
  assign wd_enable = (state == S_WAIT) && !unit_done && !wd_expired;

  seq_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  // NOTE: every register below is assigned with <= so all of them update
  // together from pre-edge values; a blocking = would let later statements
  // see the new value within the same edge and break the pipeline timing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      flags     <= '0;
      au_a      <= '0;
      au_b      <= '0;
      au_op     <= OP_ADD;
      div_start <= 1'b0;
      mul_start <= 1'b0;
    end else begin
      // Start strobes are single-cycle unless re-armed below.
      div_start <= 1'b0;
      mul_start <= 1'b0;

      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            au_a     <= op_a;
            au_b     <= op_b;
            au_op    <= op_e'(opcode);
            flags    <= '0;
            in_ready <= 1'b0;
            // Raised on the accept edge so the pulse occupies the ISSUE cycle.
            div_start <= (op_e'(opcode) == OP_DIV) &&
                         uses_unit(op_e'(opcode), op_b == '0);
            mul_start <= (op_e'(opcode) == OP_MUL);
            state    <= S_ISSUE;
          end else begin
            in_ready <= 1'b1;
          end
        end

        S_ISSUE: begin
          case (au_op)
            OP_ADD, OP_SUB: begin
              result            <= au_res;
              result_hi         <= '0;
              flags[FLAG_CARRY] <= au_cout;
              flags[FLAG_OVR]   <= au_ovr;
              out_valid         <= 1'b1;
              state             <= S_DONE;
            end
            OP_DIV, OP_MUL: begin
              if (uses_unit(au_op, au_b == '0)) begin
                state <= S_WAIT;
              end else begin
                result          <= '1;
                result_hi       <= au_a;
                flags[FLAG_DBZ] <= 1'b1;
                out_valid       <= 1'b1;
                state           <= S_DONE;
              end
            end
            default: state <= S_DONE;
          endcase
        end

        S_WAIT: begin
          // A done arriving on the last permitted cycle still wins.
          if (unit_done) begin
            if (au_op == OP_DIV) begin
              result    <= div_quot;
              result_hi <= div_rem;
            end else begin
              result          <= mul_prod[WIDTH-1:0];
              result_hi       <= mul_prod[2*WIDTH-1:WIDTH];
              flags[FLAG_OVR] <= (mul_prod[2*WIDTH-1:WIDTH] != '0);
            end
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else if (wd_expired) begin
            result              <= '0;
            result_hi           <= '0;
            flags[FLAG_TIMEOUT] <= 1'b1;
            out_valid           <= 1'b1;
            state               <= S_DONE;
          end
        end

        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            flags     <= '0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
// Self-checking bench for alu_sequencer. The bench plays the arithmetic
// datapath (combinational adder/subtractor, latency-programmable divider and
// multiplier) and compares every response against an integer-arithmetic
// reference model of the sequencer's contract.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;

  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 64;
  localparam int TW      = 7;

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] DIV = 2'b10;
  localparam logic [1:0] MUL = 2'b11;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] hi;
    logic [3:0]       flg;
  } resp_t;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         opcode;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   result;
  logic [WIDTH-1:0]   result_hi;
  logic [3:0]         flags;
  logic [WIDTH-1:0]   au_a;
  logic [WIDTH-1:0]   au_b;
  logic [1:0]         au_sel;
  logic [WIDTH-1:0]   au_res;
  logic               au_cout;
  logic               au_ovr;
  logic               div_start;
  logic               div_done;
  logic [WIDTH-1:0]   div_quot;
  logic [WIDTH-1:0]   div_rem;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  int checks = 0;
  int errors = 0;

  alu_sequencer #(
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .flags     (flags),
    .au_a      (au_a),
    .au_b      (au_b),
    .au_sel    (au_sel),
    .au_res    (au_res),
    .au_cout   (au_cout),
    .au_ovr    (au_ovr),
    .div_start (div_start),
    .div_done  (div_done),
    .div_quot  (div_quot),
    .div_rem   (div_rem),
    .mul_start (mul_start),
    .mul_done  (mul_done),
    .mul_prod  (mul_prod)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit reached before summary");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Datapath stand-in: combinational adder / subtractor driven by au_*.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0] dp_sum;
  logic [WIDTH:0] dp_dif;
  logic           dp_is_sub;

  assign dp_sum    = {1'b0, au_a} + {1'b0, au_b};
  assign dp_dif    = {1'b0, au_a} - {1'b0, au_b};
  assign dp_is_sub = (au_sel == SUB);
  assign au_res    = dp_is_sub ? dp_dif[WIDTH-1:0] : dp_sum[WIDTH-1:0];
  assign au_cout   = dp_is_sub ? dp_dif[WIDTH] : dp_sum[WIDTH];
  assign au_ovr    = dp_is_sub ?
                     ((au_a[WIDTH-1] != au_b[WIDTH-1]) && (au_res[WIDTH-1] != au_a[WIDTH-1])) :
                     ((au_a[WIDTH-1] == au_b[WIDTH-1]) && (au_res[WIDTH-1] != au_a[WIDTH-1]));

  // ---------------------------------------------------------------------------
  // Reference model: response expected for a request, from plain arithmetic.
  // ---------------------------------------------------------------------------
  function automatic resp_t model(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b, input bit timed_out);
    resp_t r;
    int ua;
    int ub;
    int sa;
    int sb;
    int s;
    int ss;
    r  = '0;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (op)
      ADD: begin
        s      = ua + ub;
        ss     = sa + sb;
        r.res  = s[7:0];
        r.flg[0] = (s > 255);
        r.flg[1] = (ss > 127) || (ss < -128);
      end
      SUB: begin
        s      = ua - ub;
        ss     = sa - sb;
        r.res  = s[7:0];
        r.flg[0] = (ua < ub);
        r.flg[1] = (ss > 127) || (ss < -128);
      end
      DIV: begin
        if (ub == 0) begin
          r.res    = 8'hFF;
          r.hi     = a;
          r.flg[2] = 1'b1;
        end else if (timed_out) begin
          r.flg[3] = 1'b1;
        end else begin
          s     = ua / ub;
          ss    = ua % ub;
          r.res = s[7:0];
          r.hi  = ss[7:0];
        end
      end
      default: begin
        if (timed_out) begin
          r.flg[3] = 1'b1;
        end else begin
          s        = ua * ub;
          r.res    = s[7:0];
          r.hi     = s[15:8];
          r.flg[1] = (s > 255);
        end
      end
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // One complete transaction. lat = cycles from the start pulse to the done
  // pulse (0 = done never comes). stray = pulse the other unit's done once.
  // hold = cycles to keep out_ready low once the response appears.
  // Called at a falling edge; returns at a falling edge.
  // ---------------------------------------------------------------------------
  task automatic run_op(input logic [1:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input int lat, input bit stray,
                        input int hold, output int valid_cyc, output resp_t got);
    int cyc;
    int start_cyc;
    int n_div;
    int n_mul;
    int exp_div;
    int exp_mul;
    int guard;
    logic [WIDTH-1:0]   cap_a;
    logic [WIDTH-1:0]   cap_b;
    logic [2*WIDTH-1:0] prod;
    out_ready = (hold == 0);
    guard = 0;
    while (in_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL in_ready_before_request got %b want 1", in_ready);
    end
    in_valid = 1'b1;
    opcode   = op;
    op_a     = a;
    op_b     = b;
    @(negedge clk);
    // Scramble the request bus so any late re-latch shows up.
    in_valid = 1'b0;
    opcode   = 2'($urandom);
    op_a     = 8'($urandom);
    op_b     = 8'($urandom);
    cyc = 1;
    start_cyc = -1;
    n_div = 0;
    n_mul = 0;
    valid_cyc = -1;
    cap_a = '0;
    cap_b = '0;
    checks++;
    if ({au_a, au_b, au_sel} !== {a, b, op}) begin
      errors++;
      $display("FAIL au_operands got a=%h b=%h sel=%h want a=%h b=%h sel=%h",
               au_a, au_b, au_sel, a, b, op);
    end
    while (cyc < 200) begin
      if (div_start === 1'b1) begin
        n_div++;
        start_cyc = cyc;
        cap_a = au_a;
        cap_b = au_b;
      end
      if (mul_start === 1'b1) begin
        n_mul++;
        start_cyc = cyc;
        cap_a = au_a;
        cap_b = au_b;
      end
      if (out_valid === 1'b1) begin
        valid_cyc = cyc;
        break;
      end
      div_done = 1'b0;
      mul_done = 1'b0;
      if (start_cyc >= 0 && lat > 0 && cyc == start_cyc + lat) begin
        if (op == DIV) begin
          div_done = 1'b1;
          div_quot = (cap_b != '0) ? cap_a / cap_b : 8'hFF;
          div_rem  = (cap_b != '0) ? cap_a % cap_b : cap_a;
        end else begin
          prod     = {8'd0, cap_a} * {8'd0, cap_b};
          mul_done = 1'b1;
          mul_prod = prod;
        end
      end
      if (stray && start_cyc >= 0 && cyc == start_cyc + 1) begin
        if (op == DIV) begin
          mul_done = 1'b1;
          mul_prod = 16'hBEEF;
        end else begin
          div_done = 1'b1;
          div_quot = 8'h5A;
          div_rem  = 8'hA5;
        end
      end
      @(negedge clk);
      cyc++;
    end
    div_done = 1'b0;
    mul_done = 1'b0;
    exp_div = (op == DIV && b != '0) ? 1 : 0;
    exp_mul = (op == MUL) ? 1 : 0;
    checks++;
    if (n_div != exp_div || n_mul != exp_mul) begin
      errors++;
      $display("FAIL start_pulses got div=%0d mul=%0d want div=%0d mul=%0d",
               n_div, n_mul, exp_div, exp_mul);
    end
    checks++;
    if (valid_cyc < 0) begin
      errors++;
      $display("FAIL out_valid_wait got no response within 200 cycles want response");
    end
    got = {result, result_hi, flags};
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, result, result_hi, flags} !== {1'b1, 1'b0, got}) begin
        errors++;
        $display("FAIL hold_stable cycle %0d got v=%b r=%b %h/%h/%b want v=1 r=0 %h/%h/%b",
                 i, out_valid, in_ready, result, result_hi, flags, got.res, got.hi, got.flg);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, flags, in_ready} !== {1'b0, 4'b0000, 1'b1}) begin
      errors++;
      $display("FAIL consume got out_valid=%b flags=%b in_ready=%b want 0 0000 1",
               out_valid, flags, in_ready);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, div_start, mul_start, result, result_hi, flags,
         au_a, au_b, au_sel} !== '0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b v=%b ds=%b ms=%b res=%h hi=%h flg=%b a=%h b=%h sel=%h want all 0",
               in_ready, out_valid, div_start, mul_start, result, result_hi, flags, au_a, au_b, au_sel);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL idle_after_reset got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_add();
    int vc;
    resp_t got;
    resp_t exp;
    run_op(ADD, 8'd200, 8'd100, 0, 1'b0, 0, vc, got);
    exp = model(ADD, 8'd200, 8'd100, 1'b0);
    checks++;
    if (got !== exp || got.res !== 8'd44 || got.flg !== 4'b0001) begin
      errors++;
      $display("FAIL add_200_100 got %h/%h/%b want %h/%h/%b", got.res, got.hi, got.flg, exp.res, exp.hi, exp.flg);
    end
    checks++;
    if (vc !== 2) begin
      errors++;
      $display("FAIL add_latency got %0d want 2", vc);
    end
  endtask

  task automatic test_sub_hold();
    int vc;
    resp_t got;
    resp_t exp;
    run_op(SUB, 8'd5, 8'd9, 0, 1'b0, 5, vc, got);
    exp = model(SUB, 8'd5, 8'd9, 1'b0);
    checks++;
    if (got !== exp || got.res !== 8'd252) begin
      errors++;
      $display("FAIL sub_5_9 got %h/%h/%b want %h/%h/%b", got.res, got.hi, got.flg, exp.res, exp.hi, exp.flg);
    end
  endtask

  task automatic test_div();
    int vc;
    resp_t got;
    resp_t exp;
    run_op(DIV, 8'd100, 8'd7, 9, 1'b1, 0, vc, got);
    exp = model(DIV, 8'd100, 8'd7, 1'b0);
    checks++;
    if (got !== exp || {got.res, got.hi} !== {8'd14, 8'd2}) begin
      errors++;
      $display("FAIL div_100_7 got %h/%h/%b want %h/%h/%b", got.res, got.hi, got.flg, exp.res, exp.hi, exp.flg);
    end
  endtask

  task automatic test_div_zero();
    int vc;
    resp_t got;
    resp_t exp;
    run_op(DIV, 8'd37, 8'd0, 5, 1'b0, 0, vc, got);
    exp = model(DIV, 8'd37, 8'd0, 1'b0);
    checks++;
    if (got !== exp || got.flg !== 4'b0100) begin
      errors++;
      $display("FAIL div_by_zero got %h/%h/%b want %h/%h/%b", got.res, got.hi, got.flg, exp.res, exp.hi, exp.flg);
    end
    checks++;
    if (vc !== 2) begin
      errors++;
      $display("FAIL div_by_zero_latency got %0d want 2", vc);
    end
  endtask

  task automatic test_mul_and_timeout();
    int vc;
    resp_t got;
    resp_t exp;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    run_op(MUL, 8'd20, 8'd15, 4, 1'b0, 0, vc, got);
    exp = model(MUL, 8'd20, 8'd15, 1'b0);
    checks++;
    if (got !== exp || {got.res, got.hi, got.flg} !== {8'h2C, 8'h01, 4'b0010}) begin
      errors++;
      $display("FAIL mul_20_15 got %h/%h/%b want %h/%h/%b", got.res, got.hi, got.flg, exp.res, exp.hi, exp.flg);
    end
    a = 8'($urandom);
    b = 8'($urandom);
    run_op(MUL, a, b, 0, 1'b0, 0, vc, got);
    exp = model(MUL, a, b, 1'b1);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL mul_timeout got %h/%h/%b want %h/%h/%b", got.res, got.hi, got.flg, exp.res, exp.hi, exp.flg);
    end
    // ISSUE cycle, TIMEOUT wait cycles, then the response cycle.
    checks++;
    if (vc !== TIMEOUT + 2) begin
      errors++;
      $display("FAIL mul_timeout_latency got %0d want %0d", vc, TIMEOUT + 2);
    end
  endtask

  // A done on the final permitted wait cycle must beat the watchdog.
  task automatic test_done_on_last_cycle();
    int vc;
    resp_t got;
    resp_t exp;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    a = 8'($urandom);
    b = 8'($urandom_range(255, 1));
    run_op(DIV, a, b, TIMEOUT, 1'b0, 0, vc, got);
    exp = model(DIV, a, b, 1'b0);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL done_on_last_wait_cycle got %h/%h/%b want %h/%h/%b",
               got.res, got.hi, got.flg, exp.res, exp.hi, exp.flg);
    end
  endtask

  task automatic test_reset_mid_op();
    int vc;
    resp_t got;
    resp_t exp;
    int guard;
    out_ready = 1'b1;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b1;
    opcode   = DIV;
    op_a     = 8'd100;
    op_b     = 8'd7;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, div_start, mul_start, result, result_hi, flags,
         au_a, au_b, au_sel} !== '0) begin
      errors++;
      $display("FAIL reset_mid_wait got rdy=%b v=%b res=%h hi=%h flg=%b a=%h b=%h sel=%h want all 0",
               in_ready, out_valid, result, result_hi, flags, au_a, au_b, au_sel);
    end
    @(negedge clk);
    div_done = 1'b1;
    div_quot = 8'd14;
    div_rem  = 8'd2;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, flags} !== 5'b0) begin
        errors++;
        $display("FAIL late_done_ignored cycle %0d got out_valid=%b flags=%b want 0 0000",
                 i, out_valid, flags);
      end
    end
    div_done = 1'b0;
    run_op(ADD, 8'd1, 8'd1, 0, 1'b0, 0, vc, got);
    exp = model(ADD, 8'd1, 8'd1, 1'b0);
    checks++;
    if (got !== exp || got.res !== 8'd2) begin
      errors++;
      $display("FAIL add_after_reset got %h/%h/%b want %h/%h/%b", got.res, got.hi, got.flg, exp.res, exp.hi, exp.flg);
    end
  endtask

  task automatic test_random();
    int vc;
    resp_t got;
    resp_t exp;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    int lat;
    bit stray;
    int hold;
    for (int n = 0; n < 30; n++) begin
      op    = 2'($urandom);
      a     = 8'($urandom);
      b     = ($urandom_range(7, 0) == 0) ? 8'd0 : 8'($urandom);
      lat   = $urandom_range(12, 1);
      stray = 1'($urandom);
      hold  = $urandom_range(2, 0);
      run_op(op, a, b, lat, stray, hold, vc, got);
      exp = model(op, a, b, 1'b0);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random_%0d op=%0d a=%h b=%h got %h/%h/%b want %h/%h/%b",
                 n, op, a, b, got.res, got.hi, got.flg, exp.res, exp.hi, exp.flg);
      end
    end
  endtask

  initial begin
    in_valid  = 1'b0;
    opcode    = 2'b00;
    op_a      = '0;
    op_b      = '0;
    out_ready = 1'b0;
    div_done  = 1'b0;
    div_quot  = '0;
    div_rem   = '0;
    mul_done  = 1'b0;
    mul_prod  = '0;
    rst       = 1'b0;

    test_reset();
    test_add();
    test_sub_hold();
    test_div();
    test_div_zero();
    test_mul_and_timeout();
    test_done_on_last_cycle();
    test_reset_mid_op();
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
